cache_axi_outstanding_limiter: RTL and testbench
================================================

Name: cache_axi_outstanding_limiter

Overview:
- Sits between the cache subsystem's single merged AXI master port and the SoC interconnect.
- Caps the number of outstanding read and write transactions, tracks R/B completions, and provides a drain handshake for fence/flush sequences.
- Combinational pass-through on all channels, except that AR/AW valid/ready are gated by counter and state logic.
- Registered counters, a drain FSM and a sticky protocol-error flag.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration (AXI widths).
- axi_req_t, logic, AXI request struct type.
- axi_rsp_t, logic, AXI response struct type.
- MaxReads, 8, maximum outstanding AR transactions (1..255).
- MaxWrites, 8, maximum outstanding AW transactions (1..255).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- axi_req_i  in  axi_req_t  request from cache subsystem.
- axi_resp_o  out  axi_rsp_t  response to cache subsystem.
- axi_req_o  out  axi_req_t  request to interconnect.
- axi_resp_i  in  axi_rsp_t  response from interconnect.
- drain_i  in  1  level request: stop issuing, wait for all completions.
- drain_ack_o  out  1  one-cycle pulse: drain complete.
- idle_o  out  1  both counters zero.
- rd_outstanding_o  out  8  current read count.
- wr_outstanding_o  out  8  current write count.
- err_o  out  1  sticky: R-last or B received with matching count zero.

Behaviour:
- Reset values:
  - Counters 0, FSM RUN, err_o 0, drain_ack_o 0, idle_o 1.
  - ar_lock and aw_lock cleared.
- Counters:
  - Width $clog2(Max+1), zero-extended to 8 bits on output.
  - rd_cnt +1 on downstream AR handshake (axi_req_o.ar_valid & axi_resp_i.ar_ready).
  - rd_cnt −1 on R handshake with r.last.
  - wr_cnt +1 on AW handshake; −1 on B handshake.
  - Simultaneous increment and decrement: count unchanged.
  - Decrement at zero: count stays 0, err_o set. err_o clears only on reset.
- Gating (AR shown; AW identical with wr_cnt/MaxWrites):
  - ar_allow = (rd_cnt < MaxReads && state == RUN) || ar_lock.
  - axi_req_o.ar_valid = axi_req_i.ar_valid & ar_allow.
  - axi_resp_o.ar_ready = axi_resp_i.ar_ready & ar_allow.
  - ar_lock is set when axi_req_o.ar_valid & !axi_resp_i.ar_ready, and cleared on handshake. Downstream valid therefore never drops before ready, even when drain asserts or counters change.
  - A count at MaxReads with a decrement in the same cycle does not allow issue until the next cycle (registered compare).
- W, R, B and all payloads pass straight through, zero latency.
- FSM:
  - RUN: drain_i=1 → DRAIN.
  - DRAIN: new AR/AW blocked (locked ones complete). When rd_cnt==0, wr_cnt==0, no lock and no W pending (w_valid low), pulse drain_ack_o for one cycle → RUN.
  - If drain_i is still high in RUN after the ack, re-enter DRAIN. The requester drops drain_i on the ack.
  - drain_i deasserted during DRAIN → RUN with no ack.
- idle_o = (rd_cnt==0 && wr_cnt==0), combinational from registers.
- Reset mid-transaction: all state cleared asynchronously. Responses after reset may set err_o; this is legal and documented.

Optional Feature:
- Macro CVA6_AXI_LIMITER_PERF_EN.
- When defined, adds outputs rd_stall_cnt_o and wr_stall_cnt_o (32 bits each). Each counts cycles where the upstream valid is high but gated by a full counter (not by drain). Both saturate at 2^32−1 and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Issue 8 back-to-back ARs, ready=1, no R: 9th AR valid is held low downstream and rd_outstanding_o=8. One R last arrives → next cycle AR passes and count returns to 8.
- AR valid with ready=0 while drain_i rises: downstream ar_valid stays 1 until ready, then drains. After R last, drain_ack_o pulses once and idle_o=1.
- Same-cycle AW handshake and B handshake at wr_cnt=3 → wr_cnt stays 3.
- B with wr_cnt=0 → err_o=1 and stays set; wr_cnt stays 0.
- Drain with 2 writes outstanding: no ack until both Bs. drain_i dropped after the first B → no ack, state returns to RUN.
- With CVA6_AXI_LIMITER_PERF_EN, hold AR valid for 5 cycles at full count → rd_stall_cnt_o=5.

Source files
------------

// File: rtl/cache_axi_outstanding_limiter.sv
// Outstanding AR/AW limiter with drain handshake between the cache AXI master and the interconnect.
// Optional stall counters are enabled with `define CVA6_AXI_LIMITER_PERF_EN.

package cache_axi_limiter_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned AxiAddrWidth;
      int unsigned AxiDataWidth;
      int unsigned AxiIdWidth;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      XLEN:         64,
      AxiAddrWidth: 32,
      AxiDataWidth: 64,
      AxiIdWidth:   4
   };

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ax_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } axi_rsp_t;

endpackage

module cache_axi_outstanding_limiter #(
   parameter cache_axi_limiter_pkg::cva6_cfg_t CVA6Cfg = cache_axi_limiter_pkg::cva6_cfg_empty,
   parameter type         axi_req_t = cache_axi_limiter_pkg::axi_req_t,
   parameter type         axi_rsp_t = cache_axi_limiter_pkg::axi_rsp_t,
   parameter int unsigned MaxReads  = 8,
   parameter int unsigned MaxWrites = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  axi_req_t    axi_req_i,
   output axi_rsp_t    axi_resp_o,
   output axi_req_t    axi_req_o,
   input  axi_rsp_t    axi_resp_i,
   input  logic        drain_i,
   output logic        drain_ack_o,
   output logic        idle_o,
   output logic [7:0]  rd_outstanding_o,
   output logic [7:0]  wr_outstanding_o,
   output logic        err_o
`ifdef CVA6_AXI_LIMITER_PERF_EN
  ,output logic [31:0] rd_stall_cnt_o,
   output logic [31:0] wr_stall_cnt_o
`endif
);

   localparam int unsigned RdW = $clog2(MaxReads + 1);
   localparam int unsigned WrW = $clog2(MaxWrites + 1);
   localparam logic [RdW-1:0] RdMax = RdW'(MaxReads);
   localparam logic [WrW-1:0] WrMax = WrW'(MaxWrites);

   if (MaxReads < 1 || MaxReads > 255 || MaxWrites < 1 || MaxWrites > 255 ||
       (CVA6Cfg.AxiDataWidth % 8) != 0) begin : g_param_err
      $error("cache_axi_outstanding_limiter: illegal limit or AXI data width");
   end

   typedef enum logic {RUN, DRAIN} state_e;

   state_e         state_q;
   logic           drain_ack_q;
   logic [RdW-1:0] rd_cnt_q, rd_cnt_d;
   logic [WrW-1:0] wr_cnt_q, wr_cnt_d;
   logic           ar_lock_q, ar_lock_d;
   logic           aw_lock_q, aw_lock_d;
   logic           err_q, err_d;

   logic ar_allow, aw_allow;
   logic ar_vld_dn, aw_vld_dn;
   logic ar_hs, aw_hs, r_last_hs, b_hs;
   logic drain_done;

   // A lock keeps a presented downstream request valid until accepted, whatever the counters or FSM do.
   assign ar_allow  = ((rd_cnt_q < RdMax) && (state_q == RUN)) || ar_lock_q;
   assign aw_allow  = ((wr_cnt_q < WrMax) && (state_q == RUN)) || aw_lock_q;
   assign ar_vld_dn = axi_req_i.ar_valid & ar_allow;
   assign aw_vld_dn = axi_req_i.aw_valid & aw_allow;
   assign ar_hs     = ar_vld_dn & axi_resp_i.ar_ready;
   assign aw_hs     = aw_vld_dn & axi_resp_i.aw_ready;
   assign r_last_hs = axi_resp_i.r_valid & axi_req_i.r_ready & axi_resp_i.r.last;
   assign b_hs      = axi_resp_i.b_valid & axi_req_i.b_ready;

   always_comb begin
      axi_req_o           = axi_req_i;
      axi_req_o.ar_valid  = ar_vld_dn;
      axi_req_o.aw_valid  = aw_vld_dn;
      axi_resp_o          = axi_resp_i;
      axi_resp_o.ar_ready = axi_resp_i.ar_ready & ar_allow;
      axi_resp_o.aw_ready = axi_resp_i.aw_ready & aw_allow;
   end

   always_comb begin
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_d     = err_q;
      ar_lock_d = ar_lock_q;
      aw_lock_d = aw_lock_q;

      if (ar_hs && !r_last_hs) begin
         rd_cnt_d = rd_cnt_q + RdW'(1);
      end else if (!ar_hs && r_last_hs) begin
         if (rd_cnt_q == '0) err_d = 1'b1;
         else                rd_cnt_d = rd_cnt_q - RdW'(1);
      end

      if (aw_hs && !b_hs) begin
         wr_cnt_d = wr_cnt_q + WrW'(1);
      end else if (!aw_hs && b_hs) begin
         if (wr_cnt_q == '0) err_d = 1'b1;
         else                wr_cnt_d = wr_cnt_q - WrW'(1);
      end

      if (ar_hs)          ar_lock_d = 1'b0;
      else if (ar_vld_dn) ar_lock_d = 1'b1;
      if (aw_hs)          aw_lock_d = 1'b0;
      else if (aw_vld_dn) aw_lock_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         ar_lock_q <= 1'b0;
         aw_lock_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         ar_lock_q <= ar_lock_d;
         aw_lock_q <= aw_lock_d;
         err_q     <= err_d;
      end
   end

   // Drain completes only once nothing is in flight and no W beat is still being presented.
   assign drain_done = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !ar_lock_q && !aw_lock_q &&
                       !axi_req_i.w_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         drain_ack_q <= 1'b0;
      end else begin
         drain_ack_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (drain_i) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!drain_i) begin
                  state_q <= RUN;
               end else if (drain_done) begin
                  drain_ack_q <= 1'b1;
                  state_q     <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef CVA6_AXI_LIMITER_PERF_EN
   logic [31:0] rd_stall_q, wr_stall_q;
   logic        rd_full_stall, wr_full_stall;

   // In RUN the only thing that can gate an unlocked request is a full counter.
   assign rd_full_stall = axi_req_i.ar_valid && !ar_allow && (state_q == RUN);
   assign wr_full_stall = axi_req_i.aw_valid && !aw_allow && (state_q == RUN);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_stall_q <= '0;
         wr_stall_q <= '0;
      end else begin
         if (rd_full_stall && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 32'd1;
         if (wr_full_stall && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 32'd1;
      end
   end

   assign rd_stall_cnt_o = rd_stall_q;
   assign wr_stall_cnt_o = wr_stall_q;
`endif

   assign drain_ack_o      = drain_ack_q;
   assign idle_o           = (rd_cnt_q == '0) && (wr_cnt_q == '0);
   assign rd_outstanding_o = 8'(rd_cnt_q);
   assign wr_outstanding_o = 8'(wr_cnt_q);
   assign err_o            = err_q;

endmodule

// File: tb/tb_cache_axi_outstanding_limiter.sv
// Random + directed bench for cache_axi_outstanding_limiter against a queue-based transaction model.
module tb_cache_axi_outstanding_limiter;
   import cache_axi_limiter_pkg::*;

   localparam int MaxR = 8;
   localparam int MaxW = 8;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   axi_req_t   req_i, req_o;
   axi_rsp_t   rsp_i, rsp_o;
   logic       drain_i;
   logic       drain_ack_o, idle_o, err_o;
   logic [7:0] rd_out, wr_out;
`ifdef CVA6_AXI_LIMITER_PERF_EN
   logic [31:0] rd_stall, wr_stall;
   longint      m_rd_stall, m_wr_stall;
`endif

   always #5 clk_i = ~clk_i;

   cache_axi_outstanding_limiter #(
      .MaxReads (MaxR),
      .MaxWrites(MaxW)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .axi_req_i       (req_i),
      .axi_resp_o      (rsp_o),
      .axi_req_o       (req_o),
      .axi_resp_i      (rsp_i),
      .drain_i         (drain_i),
      .drain_ack_o     (drain_ack_o),
      .idle_o          (idle_o),
      .rd_outstanding_o(rd_out),
      .wr_outstanding_o(wr_out),
      .err_o           (err_o)
`ifdef CVA6_AXI_LIMITER_PERF_EN
     ,.rd_stall_cnt_o  (rd_stall),
      .wr_stall_cnt_o  (wr_stall)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: outstanding transactions are queue entries.
   int       rd_q[$];
   int       wr_q[$];
   bit       m_ar_lock, m_aw_lock, m_drain, m_ack, m_err;
   bit       chk_en = 1'b0;
   bit       a_allow, w_allow, ar_go, aw_go, r_fin, b_fin, clr;
   axi_req_t e_req;
   axi_rsp_t e_rsp;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         rd_q.delete();
         wr_q.delete();
         m_ar_lock = 0; m_aw_lock = 0; m_drain = 0; m_ack = 0; m_err = 0;
`ifdef CVA6_AXI_LIMITER_PERF_EN
         m_rd_stall = 0; m_wr_stall = 0;
`endif
      end else if (chk_en) begin
         a_allow = (rd_q.size() < MaxR && !m_drain) || m_ar_lock;
         w_allow = (wr_q.size() < MaxW && !m_drain) || m_aw_lock;
         e_req = req_i;
         e_req.ar_valid = req_i.ar_valid & a_allow;
         e_req.aw_valid = req_i.aw_valid & w_allow;
         e_rsp = rsp_i;
         e_rsp.ar_ready = rsp_i.ar_ready & a_allow;
         e_rsp.aw_ready = rsp_i.aw_ready & w_allow;
         chk("req_o", 256'(req_o), 256'(e_req));
         chk("resp_o", 256'(rsp_o), 256'(e_rsp));
         chk("rd_cnt", 256'(rd_out), 256'(rd_q.size()));
         chk("wr_cnt", 256'(wr_out), 256'(wr_q.size()));
         chk("idle", 256'(idle_o), 256'(rd_q.size() == 0 && wr_q.size() == 0));
         chk("err", 256'(err_o), 256'(m_err));
         chk("drain_ack", 256'(drain_ack_o), 256'(m_ack));
`ifdef CVA6_AXI_LIMITER_PERF_EN
         chk("rd_stall", 256'(rd_stall), 256'(m_rd_stall));
         chk("wr_stall", 256'(wr_stall), 256'(m_wr_stall));
         if (req_i.ar_valid && rd_q.size() >= MaxR && !m_drain && !m_ar_lock && m_rd_stall < 64'hFFFF_FFFF)
            m_rd_stall++;
         if (req_i.aw_valid && wr_q.size() >= MaxW && !m_drain && !m_aw_lock && m_wr_stall < 64'hFFFF_FFFF)
            m_wr_stall++;
`endif
         clr   = rd_q.size() == 0 && wr_q.size() == 0 && !m_ar_lock && !m_aw_lock && !req_i.w_valid;
         ar_go = e_req.ar_valid && rsp_i.ar_ready;
         aw_go = e_req.aw_valid && rsp_i.aw_ready;
         r_fin = rsp_i.r_valid && req_i.r_ready && rsp_i.r.last;
         b_fin = rsp_i.b_valid && req_i.b_ready;
         if (ar_go) rd_q.push_back(int'(req_i.ar.id));
         if (r_fin) begin
            if (rd_q.size() > 0) void'(rd_q.pop_front());
            else m_err = 1;
         end
         if (aw_go) wr_q.push_back(int'(req_i.aw.id));
         if (b_fin) begin
            if (wr_q.size() > 0) void'(wr_q.pop_front());
            else m_err = 1;
         end
         if (ar_go) m_ar_lock = 0; else if (e_req.ar_valid) m_ar_lock = 1;
         if (aw_go) m_aw_lock = 0; else if (e_req.aw_valid) m_aw_lock = 1;
         m_ack = 0;
         if (m_drain) begin
            if (!drain_i) m_drain = 0;
            else if (clr) begin m_ack = 1; m_drain = 0; end
         end else if (drain_i) begin
            m_drain = 1;
         end
      end
   end

   task automatic tick(); @(posedge clk_i); #1; endtask
   task automatic look(); @(negedge clk_i); #1; endtask

   task automatic clear_inputs();
      req_i = '0; rsp_i = '0; drain_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      clear_inputs();
      look();
      chk("rst_rd", 256'(rd_out), 256'(0));
      chk("rst_wr", 256'(wr_out), 256'(0));
      chk("rst_idle", 256'(idle_o), 256'(1));
      chk("rst_err", 256'(err_o), 256'(0));
      chk("rst_ack", 256'(drain_ack_o), 256'(0));
      tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      clear_inputs();
      chk_en = 1'b1;
      @(posedge clk_i); #1;

      // Fill reads, then a single R-last frees one slot a cycle later.
      do_reset();
      req_i.ar_valid = 1; rsp_i.ar_ready = 1; req_i.r_ready = 1;
      repeat (8) tick();
      look();
      chk("t1_full_cnt", 256'(rd_out), 256'(8));
      chk("t1_ar_blocked", 256'(req_o.ar_valid), 256'(0));
      tick(); rsp_i.r_valid = 1; rsp_i.r.last = 1;
      look(); chk("t1_same_cycle_block", 256'(req_o.ar_valid), 256'(0));
      tick(); rsp_i.r_valid = 0;
      look();
      chk("t1_reissue", 256'(req_o.ar_valid), 256'(1));
      chk("t1_cnt7", 256'(rd_out), 256'(7));
      tick(); req_i.ar_valid = 0;
      look(); chk("t1_cnt8", 256'(rd_out), 256'(8));

      // Locked AR survives drain, then drain acks once after the R.
      do_reset();
      req_i.ar_valid = 1; rsp_i.ar_ready = 0; req_i.r_ready = 1;
      look(); chk("t2_vld_pre", 256'(req_o.ar_valid), 256'(1));
      tick(); drain_i = 1;
      look(); chk("t2_lock_hold", 256'(req_o.ar_valid), 256'(1));
      tick();
      look(); chk("t2_lock_hold2", 256'(req_o.ar_valid), 256'(1));
      tick(); rsp_i.ar_ready = 1;
      look(); chk("t2_hs", 256'(req_o.ar_valid), 256'(1));
      tick();
      look();
      chk("t2_drain_block", 256'(req_o.ar_valid), 256'(0));
      chk("t2_cnt1", 256'(rd_out), 256'(1));
      tick(); req_i.ar_valid = 0; rsp_i.r_valid = 1; rsp_i.r.last = 1;
      tick(); rsp_i.r_valid = 0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         look();
         if (drain_ack_o) acks++;
         tick();
         if (acks > 0) drain_i = 0;
      end
      chk("t2_ack_once", 256'(acks), 256'(1));
      look(); chk("t2_idle", 256'(idle_o), 256'(1));

      // Simultaneous AW and B at wr_cnt=3.
      do_reset();
      req_i.aw_valid = 1; rsp_i.aw_ready = 1; req_i.b_ready = 1;
      repeat (3) tick();
      rsp_i.b_valid = 1;
      look(); chk("t3_pre", 256'(wr_out), 256'(3));
      tick(); req_i.aw_valid = 0; rsp_i.b_valid = 0;
      look(); chk("t3_same", 256'(wr_out), 256'(3));

      // B with nothing outstanding.
      do_reset();
      req_i.b_ready = 1; rsp_i.b_valid = 1;
      tick(); rsp_i.b_valid = 0;
      look();
      chk("t4_err", 256'(err_o), 256'(1));
      chk("t4_wr0", 256'(wr_out), 256'(0));
      repeat (3) tick();
      look(); chk("t4_err_sticky", 256'(err_o), 256'(1));

      // Drain with two writes; abandoned after the first B.
      do_reset();
      req_i.aw_valid = 1; rsp_i.aw_ready = 1; req_i.b_ready = 1;
      repeat (2) tick();
      req_i.aw_valid = 0; drain_i = 1;
      for (int i = 0; i < 4; i++) begin
         look(); chk("t5_no_ack_2wr", 256'(drain_ack_o), 256'(0)); tick();
      end
      rsp_i.b_valid = 1;
      tick(); rsp_i.b_valid = 0; drain_i = 0;
      for (int i = 0; i < 4; i++) begin
         look(); chk("t5_no_ack_abort", 256'(drain_ack_o), 256'(0)); tick();
      end
      req_i.aw_valid = 1; rsp_i.aw_ready = 0;
      look();
      chk("t5_run_again", 256'(req_o.aw_valid), 256'(1));
      chk("t5_wr1", 256'(wr_out), 256'(1));

`ifdef CVA6_AXI_LIMITER_PERF_EN
      do_reset();
      req_i.ar_valid = 1; rsp_i.ar_ready = 1;
      repeat (13) tick();
      req_i.ar_valid = 0;
      look(); chk("t6_rd_stall", 256'(rd_stall), 256'(5));
`endif

      // Randomized traffic with a mid-run reset.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         req_i.ar_valid = ($urandom_range(0, 2) != 0);
         req_i.ar.id    = 4'($urandom);
         req_i.ar.addr  = $urandom;
         req_i.ar.len   = 8'($urandom);
         req_i.aw_valid = ($urandom_range(0, 2) != 0);
         req_i.aw.id    = 4'($urandom);
         req_i.aw.addr  = $urandom;
         req_i.w_valid  = ($urandom_range(0, 2) == 0);
         req_i.w.data   = {$urandom, $urandom};
         req_i.w.strb   = 8'($urandom);
         req_i.w.last   = 1'($urandom);
         req_i.r_ready  = ($urandom_range(0, 3) != 0);
         req_i.b_ready  = ($urandom_range(0, 3) != 0);
         rsp_i.ar_ready = 1'($urandom);
         rsp_i.aw_ready = 1'($urandom);
         rsp_i.w_ready  = 1'($urandom);
         rsp_i.r_valid  = (rd_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
         rsp_i.r.last   = ($urandom_range(0, 2) != 0);
         rsp_i.r.data   = {$urandom, $urandom};
         rsp_i.r.id     = 4'($urandom);
         rsp_i.b_valid  = (wr_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
         rsp_i.b.resp   = 2'($urandom);
         if (drain_ack_o) drain_i = 1'b0;
         else if ($urandom_range(0, 29) == 0) drain_i = ~drain_i;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
